// File: rtl/legv8_pkg.sv
// Shared LEGv8 writeback types.
// Op encoding and the zero-register index.
package legv8_pkg;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_ALU   = 3'd1,
      OP_LINK  = 3'd2,
      OP_LD_X  = 3'd3,
      OP_LD_W  = 3'd4,
      OP_LD_SW = 3'd5,
      OP_LD_H  = 3'd6,
      OP_LD_B  = 3'd7
   } wb_op_t;

   localparam logic [4:0] XZR_IDX = 5'd31;

   function automatic logic is_load(input wb_op_t op);
      return op inside {OP_LD_X, OP_LD_W, OP_LD_SW, OP_LD_H, OP_LD_B};
   endfunction

endpackage

// File: rtl/load_ext.sv
// Load data extension for the writeback stage.
// Purely combinational: op + raw right-aligned data -> register value.
module load_ext
   import legv8_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  wb_op_t            op_i,
   input  logic [DATA_W-1:0] raw_i,
   output logic [DATA_W-1:0] ext_o
);

   always_comb begin
      ext_o = raw_i;
      case (op_i)
         OP_LD_W:  ext_o = {{(DATA_W-32){1'b0}}, raw_i[31:0]};
         OP_LD_SW: ext_o = {{(DATA_W-32){raw_i[31]}}, raw_i[31:0]};
         OP_LD_H:  ext_o = {{(DATA_W-16){1'b0}}, raw_i[15:0]};
         OP_LD_B:  ext_o = {{(DATA_W-8){1'b0}}, raw_i[7:0]};
         default:  ext_o = raw_i;
      endcase
   end

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: retires ALU/link results immediately and
// parks loads in WAIT_MEM until the memory response arrives.
module reg_writeback
   import legv8_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [2:0]        IN_OP,
   input  logic [4:0]        IN_RD,
   input  logic [DATA_W-1:0] IN_ALU,
   input  logic [DATA_W-1:0] IN_LINK,
   input  logic              MEM_RVALID,
   input  logic [DATA_W-1:0] MEM_RDATA,
   output logic              REG_WRITE,
   output logic [4:0]        WR_REG,
   output logic [DATA_W-1:0] WR_DATA,
   output logic              LD_PEND,
   output logic [4:0]        LD_PEND_RD,
   output logic [CNT_W-1:0]  RETIRED
);

   typedef enum logic {S_IDLE, S_WAIT_MEM} state_e;

   state_e            state_q;
   wb_op_t            ld_op_q;
   logic [4:0]        ld_rd_q;
   logic              we_q;
   logic [4:0]        wr_reg_q;
   logic [DATA_W-1:0] wr_data_q;
   logic              pend_q;
   logic [CNT_W-1:0]  ret_q;

   wb_op_t            op_d;
   logic [DATA_W-1:0] ext_d;

   assign op_d = wb_op_t'(IN_OP);

   load_ext #(.DATA_W(DATA_W)) u_ext (
      .op_i  (ld_op_q),
      .raw_i (MEM_RDATA),
      .ext_o (ext_d)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         ld_op_q   <= OP_NONE;
         ld_rd_q   <= '0;
         we_q      <= 1'b0;
         wr_reg_q  <= '0;
         wr_data_q <= '0;
         pend_q    <= 1'b0;
         ret_q     <= '0;
      end else begin
         we_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (IN_VALID) begin
                  if (is_load(op_d)) begin
                     state_q <= S_WAIT_MEM;
                     ld_op_q <= op_d;
                     ld_rd_q <= IN_RD;
                     pend_q  <= 1'b1;
                  end else begin
                     ret_q <= ret_q + CNT_W'(1);
                     if (op_d inside {OP_ALU, OP_LINK}
                         && IN_RD != XZR_IDX) begin
                        we_q      <= 1'b1;
                        wr_reg_q  <= IN_RD;
                        wr_data_q <= (op_d == OP_ALU) ? IN_ALU
                                                      : IN_LINK;
                     end
                  end
               end
            end
            S_WAIT_MEM: begin
               // XZR loads still consume the response, just no write
               if (MEM_RVALID) begin
                  state_q <= S_IDLE;
                  pend_q  <= 1'b0;
                  ret_q   <= ret_q + CNT_W'(1);
                  if (ld_rd_q != XZR_IDX) begin
                     we_q      <= 1'b1;
                     wr_reg_q  <= ld_rd_q;
                     wr_data_q <= ext_d;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign IN_READY   = (state_q == S_IDLE);
   assign REG_WRITE  = we_q;
   assign WR_REG     = wr_reg_q;
   assign WR_DATA    = wr_data_q;
   assign LD_PEND    = pend_q;
   assign LD_PEND_RD = ld_rd_q;
   assign RETIRED    = ret_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback.
// Reference model tracks pending load, retire count and expected writes.
module tb_reg_writeback;
   import legv8_pkg::*;

   localparam int DW = 64;
   localparam int CW = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          IN_VALID;
   logic          IN_READY;
   logic [2:0]    IN_OP;
   logic [4:0]    IN_RD;
   logic [DW-1:0] IN_ALU;
   logic [DW-1:0] IN_LINK;
   logic          MEM_RVALID;
   logic [DW-1:0] MEM_RDATA;
   logic          REG_WRITE;
   logic [4:0]    WR_REG;
   logic [DW-1:0] WR_DATA;
   logic          LD_PEND;
   logic [4:0]    LD_PEND_RD;
   logic [CW-1:0] RETIRED;

   int total = 0;
   int bad = 0;

   bit            m_busy;
   logic [4:0]    m_prd;
   logic [2:0]    m_pop;
   int            m_ret;
   bit            e_we;
   logic [4:0]    e_reg;
   logic [DW-1:0] e_data;

   reg_writeback #(.DATA_W(DW), .CNT_W(CW)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .IN_VALID   (IN_VALID),
      .IN_READY   (IN_READY),
      .IN_OP      (IN_OP),
      .IN_RD      (IN_RD),
      .IN_ALU     (IN_ALU),
      .IN_LINK    (IN_LINK),
      .MEM_RVALID (MEM_RVALID),
      .MEM_RDATA  (MEM_RDATA),
      .REG_WRITE  (REG_WRITE),
      .WR_REG     (WR_REG),
      .WR_DATA    (WR_DATA),
      .LD_PEND    (LD_PEND),
      .LD_PEND_RD (LD_PEND_RD),
      .RETIRED    (RETIRED)
   );

   always #5 CLK = ~CLK;

   function automatic logic [DW-1:0] ext(input logic [2:0] op,
                                         input logic [DW-1:0] raw);
      logic [DW-1:0] lo;
      lo = raw % 64'h1_0000_0000;
      case (op)
         3'd4: return lo;
         3'd5: return (lo >= 64'h8000_0000) ? lo - 64'h1_0000_0000 : lo;
         3'd6: return raw % 64'd65536;
         3'd7: return raw % 64'd256;
         default: return raw;
      endcase
   endfunction

   task automatic tick(input logic r, input logic v,
                       input logic [2:0] op, input logic [4:0] rd,
                       input logic [DW-1:0] alu, input logic [DW-1:0] link,
                       input logic rv, input logic [DW-1:0] rdata);
      RST = r; IN_VALID = v; IN_OP = op; IN_RD = rd;
      IN_ALU = alu; IN_LINK = link; MEM_RVALID = rv; MEM_RDATA = rdata;
      e_we = 0;
      if (r) begin
         m_busy = 0; m_prd = 0; m_pop = 0; m_ret = 0;
         e_reg = 0; e_data = 0;
      end else if (!m_busy) begin
         if (v && op >= 3) begin
            m_busy = 1; m_prd = rd; m_pop = op;
         end else if (v) begin
            m_ret = (m_ret + 1) % (1 << CW);
            if (op != 0 && rd != 31) begin
               e_we = 1; e_reg = rd;
               e_data = (op == 1) ? alu : link;
            end
         end
      end else if (rv) begin
         m_busy = 0;
         m_ret = (m_ret + 1) % (1 << CW);
         if (m_prd != 31) begin
            e_we = 1; e_reg = m_prd; e_data = ext(m_pop, rdata);
         end
      end
      @(posedge CLK); #1;
   endtask

   task automatic idle(input logic rv);
      tick(0, 0, 3'd0, 5'd0, '0, '0, rv, 64'hDEAD_BEEF_CAFE_F00D);
   endtask

   task automatic do_reset();
      tick(1, 0, 3'd0, 5'd0, '0, '0, 0, '0);
      tick(1, 1, 3'd1, 5'd4, 64'h55, '0, 1, 64'h77);
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({REG_WRITE, WR_REG, WR_DATA, LD_PEND, LD_PEND_RD, RETIRED} !== '0) begin
         bad++;
         $display("FAIL reset_state: got we=%b reg=%0d data=%h pend=%b prd=%0d ret=%0d want all 0",
                  REG_WRITE, WR_REG, WR_DATA, LD_PEND, LD_PEND_RD, RETIRED);
      end
      total++;
      if (IN_READY !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready: got %b want 1", IN_READY);
      end
   endtask

   task automatic test_alu();
      do_reset();
      tick(0, 1, 3'(OP_ALU), 5'd5, 64'h1234, 64'h99, 0, '0);
      total++;
      if ({REG_WRITE, WR_REG, WR_DATA, RETIRED} !== {1'b1, 5'd5, 64'h1234, 4'd1}) begin
         bad++;
         $display("FAIL alu_write: got we=%b reg=%0d data=%h ret=%0d want 1/5/1234/1",
                  REG_WRITE, WR_REG, WR_DATA, RETIRED);
      end
      idle(0);
      total++;
      if ({REG_WRITE, WR_REG, WR_DATA} !== {1'b0, 5'd5, 64'h1234}) begin
         bad++;
         $display("FAIL alu_hold: got we=%b reg=%0d data=%h want 0/5/1234",
                  REG_WRITE, WR_REG, WR_DATA);
      end
   endtask

   task automatic test_load_sw();
      int lows;
      do_reset();
      tick(0, 1, 3'(OP_LD_SW), 5'd3, 64'h1, 64'h2, 0, '0);
      lows = 0;
      for (int i = 0; i < 4; i++) begin
         if (IN_READY === 1'b0 && LD_PEND === 1'b1 && LD_PEND_RD === 5'd3)
            lows++;
         tick(0, 1, 3'(OP_ALU), 5'd9, 64'h5, '0, (i == 3), 64'h8000_0000);
      end
      total++;
      if (lows !== 4) begin
         bad++;
         $display("FAIL ldsw_wait: got %0d pending cycles want 4", lows);
      end
      total++;
      if ({REG_WRITE, WR_REG, WR_DATA} !== {1'b1, 5'd3, 64'hFFFF_FFFF_8000_0000}) begin
         bad++;
         $display("FAIL ldsw_data: got we=%b reg=%0d data=%h want 1/3/ffffffff80000000",
                  REG_WRITE, WR_REG, WR_DATA);
      end
      total++;
      if ({IN_READY, LD_PEND, RETIRED} !== {1'b1, 1'b0, 4'd1}) begin
         bad++;
         $display("FAIL ldsw_done: got rdy=%b pend=%b ret=%0d want 1/0/1",
                  IN_READY, LD_PEND, RETIRED);
      end
   endtask

   task automatic test_xzr_load();
      int r0;
      r0 = m_ret;
      tick(0, 1, 3'(OP_LD_B), 5'd31, '0, '0, 0, '0);
      idle(1'b0);
      tick(0, 0, 3'd0, 5'd0, '0, '0, 1, 64'hFF);
      total++;
      if ({REG_WRITE, IN_READY, LD_PEND} !== 3'b010) begin
         bad++;
         $display("FAIL xzr_load: got we=%b rdy=%b pend=%b want 0/1/0",
                  REG_WRITE, IN_READY, LD_PEND);
      end
      total++;
      if (RETIRED !== CW'(r0 + 1)) begin
         bad++;
         $display("FAIL xzr_retire: got %0d want %0d", RETIRED, CW'(r0 + 1));
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         tick(0, 1, 3'(OP_ALU), 5'(i), 64'(i * 16), '0, 0, '0);
         total++;
         if ({REG_WRITE, WR_REG, WR_DATA} !== {1'b1, 5'(i), 64'(i * 16)}) begin
            bad++;
            $display("FAIL b2b_%0d: got we=%b reg=%0d data=%h want 1/%0d/%h",
                     i, REG_WRITE, WR_REG, WR_DATA, i, 64'(i * 16));
         end
      end
   endtask

   task automatic test_reset_wait();
      do_reset();
      tick(0, 1, 3'(OP_LD_X), 5'd7, '0, '0, 0, '0);
      idle(0);
      tick(1, 0, 3'd0, 5'd0, '0, '0, 1, 64'h42);
      idle(1);
      total++;
      if ({REG_WRITE, LD_PEND, RETIRED, IN_READY} !== {1'b0, 1'b0, 4'd0, 1'b1}) begin
         bad++;
         $display("FAIL reset_wait: got we=%b pend=%b ret=%0d rdy=%b want 0/0/0/1",
                  REG_WRITE, LD_PEND, RETIRED, IN_READY);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 15; i++)
         tick(0, 1, 3'(OP_NONE), 5'd2, '0, '0, 0, '0);
      total++;
      if ({RETIRED, REG_WRITE} !== {4'd15, 1'b0}) begin
         bad++;
         $display("FAIL wrap_pre: got ret=%0d we=%b want 15/0", RETIRED, REG_WRITE);
      end
      tick(0, 1, 3'(OP_LINK), 5'd9, 64'h1, 64'h404, 0, '0);
      total++;
      if ({RETIRED, REG_WRITE, WR_DATA} !== {4'd0, 1'b1, 64'h404}) begin
         bad++;
         $display("FAIL wrap: got ret=%0d we=%b data=%h want 0/1/404",
                  RETIRED, REG_WRITE, WR_DATA);
      end
   endtask

   task automatic test_random();
      logic r, v, rv;
      logic [2:0] op;
      logic [4:0] rd;
      do_reset();
      for (int i = 0; i < 500; i++) begin
         r  = ($urandom_range(0, 63) == 0);
         v  = ($urandom_range(0, 3) != 0);
         rv = ($urandom_range(0, 2) == 0);
         op = 3'($urandom);
         rd = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom);
         tick(r, v, op, rd, {$urandom, $urandom}, {$urandom, $urandom},
              rv, {$urandom, $urandom});
         total++;
         if ({REG_WRITE, WR_REG, WR_DATA, LD_PEND, LD_PEND_RD, RETIRED, IN_READY}
             !== {e_we, e_reg, e_data, m_busy, m_prd, CW'(m_ret), !m_busy}) begin
            bad++;
            $display("FAIL rand_%0d: got we=%b reg=%0d data=%h pend=%b prd=%0d ret=%0d rdy=%b want %b/%0d/%h/%b/%0d/%0d/%b",
                     i, REG_WRITE, WR_REG, WR_DATA, LD_PEND, LD_PEND_RD, RETIRED,
                     IN_READY, e_we, e_reg, e_data, m_busy, m_prd, m_ret, !m_busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_sw();
      test_xzr_load();
      test_back_to_back();
      test_reset_wait();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
